// File: rtl/calculator_bcd_converter_pkg.sv
// Shared calculator definitions: default datapath widths and the one-hot
// state encoding used by the BCD conversion stage.
package calculator_bcd_converter_pkg;

    localparam int unsigned DEF_RESULT_WIDTH   = 18;
    localparam int unsigned DEF_DIGIT_COUNT    = 6;
    localparam bit          DEF_SIGNED_DISPLAY = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_SHIFT = 3'b010,
        ST_DONE  = 3'b100
    } conv_state_e;

endpackage

// File: rtl/calculator_bcd_converter_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more
// so that the following left shift carries correctly into the next digit.
module calculator_bcd_converter_digit_adjust (
    input  logic [3:0] d,
    output logic [3:0] adj_c
);

    assign adj_c = (d >= 4'd5) ? (d + 4'd3) : d;

endmodule

// File: rtl/calculator_bcd_converter.sv
// Binary-to-BCD converter for the calculator result path: serial double-dabble,
// optional sign/magnitude display, and a one-entry pending slot for requests
// that arrive mid-conversion.
module calculator_bcd_converter
    import calculator_bcd_converter_pkg::*;
#(
    parameter int unsigned RESULT_WIDTH   = DEF_RESULT_WIDTH,
    parameter int unsigned DIGIT_COUNT    = DEF_DIGIT_COUNT,
    parameter bit          SIGNED_DISPLAY = DEF_SIGNED_DISPLAY
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       RESULT_READY,
    input  logic [RESULT_WIDTH-1:0]    RESULT_DATA,
    output logic [DIGIT_COUNT*4-1:0]   BCD_DATA,
    output logic                       BCD_NEGATIVE,
    output logic                       BCD_VALID,
    output logic                       BUSY
);

    localparam int unsigned BCD_W = DIGIT_COUNT * 4;
    localparam int unsigned CNT_W = $clog2(RESULT_WIDTH + 1);

    conv_state_e               state_q, state_d;
    logic [BCD_W-1:0]          work_q, work_d;
    logic [RESULT_WIDTH-1:0]   operand_q, operand_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      sign_q, sign_d;
    logic                      pend_q, pend_d;
    logic [RESULT_WIDTH-1:0]   pend_data_q, pend_data_d;
    logic                      ready_hist_q, ready_hist_d;
    logic [BCD_W-1:0]          bcd_data_q, bcd_data_d;
    logic                      bcd_neg_q, bcd_neg_d;
    logic                      bcd_valid_q, bcd_valid_d;
    logic                      busy_q, busy_d;

    logic                      req_c;
    logic                      start_c;
    logic [RESULT_WIDTH-1:0]   start_data_c;
    logic [BCD_W-1:0]          adj_c;

    assign req_c = RESULT_READY & ~ready_hist_q;

    for (genvar g = 0; g < DIGIT_COUNT; g++) begin : g_digit
        calculator_bcd_converter_digit_adjust u_adj (
            .d     (work_q[g*4 +: 4]),
            .adj_c (adj_c[g*4 +: 4])
        );
    end

    always_comb begin
        state_d      = state_q;
        work_d       = work_q;
        operand_d    = operand_q;
        cnt_d        = cnt_q;
        sign_d       = sign_q;
        pend_d       = pend_q;
        pend_data_d  = pend_data_q;
        ready_hist_d = RESULT_READY;
        bcd_data_d   = bcd_data_q;
        bcd_neg_d    = bcd_neg_q;
        bcd_valid_d  = 1'b0;
        busy_d       = busy_q;
        start_c      = 1'b0;
        start_data_c = RESULT_DATA;

        case (state_q)
            ST_IDLE: begin
                // A parked request beats a fresh one; the fresh one is parked instead.
                if (pend_q) begin
                    start_c      = 1'b1;
                    start_data_c = pend_data_q;
                    pend_d       = 1'b0;
                end else if (req_c) begin
                    start_c = 1'b1;
                end
            end
            ST_SHIFT: begin
                work_d    = {adj_c[BCD_W-2:0], operand_q[RESULT_WIDTH-1]};
                operand_d = {operand_q[RESULT_WIDTH-2:0], 1'b0};
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_data_d  = work_q;
                bcd_neg_d   = sign_q;
                bcd_valid_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (req_c && ((state_q != ST_IDLE) || pend_q)) begin
            pend_d      = 1'b1;
            pend_data_d = RESULT_DATA;
        end

        if (start_c) begin
            if (SIGNED_DISPLAY && start_data_c[RESULT_WIDTH-1]) begin
                operand_d = ~start_data_c + RESULT_WIDTH'(1);
                sign_d    = 1'b1;
            end else begin
                operand_d = start_data_c;
                sign_d    = 1'b0;
            end
            work_d  = '0;
            cnt_d   = CNT_W'(RESULT_WIDTH);
            busy_d  = 1'b1;
            state_d = ST_SHIFT;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            work_q       <= '0;
            operand_q    <= '0;
            cnt_q        <= '0;
            sign_q       <= 1'b0;
            pend_q       <= 1'b0;
            pend_data_q  <= '0;
            ready_hist_q <= 1'b0;
            bcd_data_q   <= '0;
            bcd_neg_q    <= 1'b0;
            bcd_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            work_q       <= work_d;
            operand_q    <= operand_d;
            cnt_q        <= cnt_d;
            sign_q       <= sign_d;
            pend_q       <= pend_d;
            pend_data_q  <= pend_data_d;
            ready_hist_q <= ready_hist_d;
            bcd_data_q   <= bcd_data_d;
            bcd_neg_q    <= bcd_neg_d;
            bcd_valid_q  <= bcd_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign BCD_DATA     = bcd_data_q;
    assign BCD_NEGATIVE = bcd_neg_q;
    assign BCD_VALID    = bcd_valid_q;
    assign BUSY         = busy_q;

endmodule

// File: tb/tb_calculator_bcd_converter.sv
// Directed bench for calculator_bcd_converter: a signed-display and an
// unsigned-display instance share stimulus; expected BCD values are hand-computed.
module tb_calculator_bcd_converter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic [17:0] data;
    logic [23:0] bcd_s, bcd_u;
    logic        neg_s, neg_u, val_s, val_u, busy_s, busy_u;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int          vcnt_s = 0;
    int          vcnt_u = 0;

    always #5 clk = ~clk;

    calculator_bcd_converter #(
        .RESULT_WIDTH(18), .DIGIT_COUNT(6), .SIGNED_DISPLAY(1'b1)
    ) dut_s (
        .CLK(clk), .RESET(rst), .RESULT_READY(ready), .RESULT_DATA(data),
        .BCD_DATA(bcd_s), .BCD_NEGATIVE(neg_s), .BCD_VALID(val_s), .BUSY(busy_s)
    );

    calculator_bcd_converter #(
        .RESULT_WIDTH(18), .DIGIT_COUNT(6), .SIGNED_DISPLAY(1'b0)
    ) dut_u (
        .CLK(clk), .RESET(rst), .RESULT_READY(ready), .RESULT_DATA(data),
        .BCD_DATA(bcd_u), .BCD_NEGATIVE(neg_u), .BCD_VALID(val_u), .BUSY(busy_u)
    );

    // Count cycles with VALID high, sampled shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (val_s) vcnt_s++;
        if (val_u) vcnt_u++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int max_cyc, output int cyc);
        cyc = 0;
        while (cyc < max_cyc) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (val_s) break;
        end
        if (!val_s) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic request(input logic [17:0] v);
        @(negedge clk);
        data  = v;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic do_conv(input string tag, input logic [17:0] v,
                           input logic [23:0] exp_s, input logic exp_ns,
                           input logic [23:0] exp_u, input logic exp_nu);
        int cyc;
        int base_s, base_u;
        base_s = vcnt_s;
        base_u = vcnt_u;
        request(v);
        wait_valid(tag, 40, cyc);
        check_val({tag, "_latency"}, 32'(cyc), 32'd19);
        check_val({tag, "_bcd_s"}, 32'(bcd_s), 32'(exp_s));
        check_val({tag, "_neg_s"}, 32'(neg_s), 32'(exp_ns));
        check_val({tag, "_bcd_u"}, 32'(bcd_u), 32'(exp_u));
        check_val({tag, "_neg_u"}, 32'(neg_u), 32'(exp_nu));
        check_val({tag, "_busy_done"}, 32'(busy_s), 32'd0);
        repeat (3) @(negedge clk);
        check_val({tag, "_pulses_s"}, 32'(vcnt_s - base_s), 32'd1);
        check_val({tag, "_pulses_u"}, 32'(vcnt_u - base_u), 32'd1);
        check_val({tag, "_hold_s"}, 32'(bcd_s), 32'(exp_s));
    endtask

    initial begin
        int cyc;
        int base;
        rst   = 1'b1;
        ready = 1'b0;
        data  = '0;
        repeat (3) @(negedge clk);
        check_val("rst_bcd", 32'(bcd_s), 32'd0);
        check_val("rst_neg", 32'(neg_s), 32'd0);
        check_val("rst_valid", 32'(val_s), 32'd0);
        check_val("rst_busy", 32'(busy_s), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_conv("zero",     18'h00000, 24'h000000, 1'b0, 24'h000000, 1'b0);
        do_conv("all_ones", 18'h3FFFF, 24'h000001, 1'b1, 24'h262143, 1'b0);
        do_conv("most_neg", 18'h20000, 24'h131072, 1'b1, 24'h131072, 1'b0);
        do_conv("pos",      18'h1E240, 24'h123456, 1'b0, 24'h123456, 1'b0);

        // Two requests during a conversion: only the latest is kept.
        base = vcnt_s;
        request(18'd100);
        repeat (3) @(negedge clk);
        check_val("pend_busy", 32'(busy_s), 32'd1);
        request(18'd7);
        request(18'd42);
        wait_valid("pend1", 40, cyc);
        check_val("pend1_bcd", 32'(bcd_s), 32'h000100);
        wait_valid("pend2", 40, cyc);
        check_val("pend2_latency", 32'(cyc), 32'd20);
        check_val("pend2_bcd_s", 32'(bcd_s), 32'h000042);
        check_val("pend2_bcd_u", 32'(bcd_u), 32'h000042);
        repeat (40) @(negedge clk);
        check_val("pend_pulses", 32'(vcnt_s - base), 32'd2);

        // Level held high yields a single conversion.
        base = vcnt_s;
        @(negedge clk);
        data  = 18'd5;
        ready = 1'b1;
        repeat (30) @(negedge clk);
        ready = 1'b0;
        repeat (30) @(negedge clk);
        check_val("held_pulses", 32'(vcnt_s - base), 32'd1);
        check_val("held_bcd_s", 32'(bcd_s), 32'h000005);
        check_val("held_bcd_u", 32'(bcd_u), 32'h000005);

        // Reset after the tenth shift aborts; READY high at release is a new edge.
        base = vcnt_s;
        request(18'd999);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_val("abort_busy_pre", 32'(busy_s), 32'd1);
        rst = 1'b1;
        #1;
        check_val("abort_bcd", 32'(bcd_s), 32'd0);
        check_val("abort_neg", 32'(neg_s), 32'd0);
        check_val("abort_busy", 32'(busy_s), 32'd0);
        check_val("abort_valid", 32'(val_s), 32'd0);
        data  = 18'd999;
        ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_valid("rst_rel", 40, cyc);
        check_val("rst_rel_latency", 32'(cyc), 32'd20);
        check_val("rst_rel_bcd", 32'(bcd_s), 32'h000999);
        check_val("rst_rel_neg", 32'(neg_s), 32'd0);
        ready = 1'b0;
        repeat (5) @(negedge clk);
        check_val("abort_pulses", 32'(vcnt_s - base), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
